// File: rtl/chan_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chan_sel_pkg
//  Brief    : Shared types and constants for the channel select scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package chan_sel_pkg;

  // Scanner controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DWELL   = 2'd1,
    PRESENT = 2'd2
  } cs_state_t;

  // Operating modes, latched on an accepted start
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : chan_sel_pkg
`default_nettype wire

// File: rtl/chan_select_scanner_dwell_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_counter
//  Brief    : Settle-time counter; counts 0..DWELL-1 while enabled and flags
//             the terminal count so the controller knows when to sample.
//  Revision : 1.0 - initial release
// ============================================================================
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CW-1:0] c_last = CW'(DWELL - 1);

  logic [CW-1:0] r_count;

  assign tc = (r_count == c_last);

  // Count up while enabled, wrap to zero after the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tc ? '0 : r_count + CW'(1);
    end
  end

endmodule : dwell_counter
`default_nettype wire

// File: rtl/chan_select_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : chan_select_scanner
//  Brief    : Registered N:1 channel selector with MANUAL single-shot and
//             round-robin SCAN modes, a settle dwell per selection and a
//             valid/ready output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module chan_select_scanner #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1,
  parameter int DWELL    = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          dout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           sel_out,
  output logic                      wrap,
  output logic                      sel_err
);

  import chan_sel_pkg::*;

  localparam logic [SELW-1:0] c_last_chan = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]   c_num_chan  = (SELW+1)'(CHANNELS);

  cs_state_t        r_state;
  cs_state_t        w_state_next;
  logic             r_mode;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic [SELW-1:0]  r_sel;
  logic             r_wrap;
  logic             r_sel_err;

  logic             w_accept;
  logic             w_sample;
  logic             w_handshake;
  logic             w_advance;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic             w_tc;
  logic             w_sel_oob;
  logic [WIDTH-1:0] w_chan;

  // Out-of-range manual request (only possible when CHANNELS is not a power of two)
  assign w_sel_oob = ({1'b0, sel_in} >= c_num_chan);

  // Selected channel; r_sel is always kept below CHANNELS
  assign w_chan = din[int'(r_sel)*WIDTH +: WIDTH];

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_cnt_clear),
    .enable (w_cnt_en),
    .tc     (w_tc)
  );

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= chan_sel_pkg::IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath strobes; stop always beats start and sampling
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_handshake  = 1'b0;
    w_advance    = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      chan_sel_pkg::IDLE: begin
        if (start && !stop) begin
          w_accept     = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = chan_sel_pkg::DWELL;
        end
      end
      chan_sel_pkg::DWELL: begin
        if (stop) begin
          w_state_next = chan_sel_pkg::IDLE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_tc) begin
            w_sample     = 1'b1;
            w_state_next = chan_sel_pkg::PRESENT;
          end
        end
      end
      chan_sel_pkg::PRESENT: begin
        // A pending sample is never dropped, even when stop is requested
        if (r_valid && out_ready) begin
          w_handshake = 1'b1;
          if (r_mode == MODE_SCAN && !stop) begin
            w_advance    = 1'b1;
            w_cnt_clear  = 1'b1;
            w_state_next = chan_sel_pkg::DWELL;
          end else begin
            w_state_next = chan_sel_pkg::IDLE;
          end
        end
      end
      default: begin
        w_state_next = chan_sel_pkg::IDLE;
      end
    endcase
  end

  // Mode/select latch, output sample register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_MANUAL;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_sel     <= '0;
      r_wrap    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_wrap    <= 1'b0;
      r_sel_err <= 1'b0;
      if (w_accept) begin
        r_mode <= mode;
        // SCAN keeps the current channel so a stopped scan resumes in place
        if (mode == MODE_MANUAL) begin
          if (w_sel_oob) begin
            r_sel     <= c_last_chan;
            r_sel_err <= 1'b1;
          end else begin
            r_sel <= sel_in;
          end
        end
      end
      if (w_sample) begin
        r_dout  <= w_chan;
        r_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_valid <= 1'b0;
      end
      if (w_advance) begin
        if (r_sel == c_last_chan) begin
          r_sel  <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_sel <= r_sel + SELW'(1);
        end
      end
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_valid;
  assign sel_out   = r_sel;
  assign wrap      = r_wrap;
  assign sel_err   = r_sel_err;

endmodule : chan_select_scanner
`default_nettype wire

// File: tb/tb_chan_select_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chan_select_scanner
//  Brief    : Directed self-checking bench for chan_select_scanner
//             (main instance 4x1 bit, DWELL 4; second instance with 3 channels).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_chan_select_scanner;

  logic       clk;
  logic       rst_n;

  // 4-channel instance
  logic [3:0] din;
  logic       mode;
  logic [1:0] sel_in;
  logic       start;
  logic       stop;
  logic       out_ready;
  logic [0:0] dout;
  logic       out_valid;
  logic [1:0] sel_out;
  logic       wrap;
  logic       sel_err;

  // 3-channel instance
  logic [2:0] din3;
  logic       mode3;
  logic [1:0] sel_in3;
  logic       start3;
  logic       stop3;
  logic       ready3;
  logic [0:0] dout3;
  logic       valid3;
  logic [1:0] sel_out3;
  logic       wrap3;
  logic       sel_err3;

  int n_cmp;
  int n_bad;

  chan_select_scanner #(.CHANNELS(4), .WIDTH(1), .DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel_in(sel_in),
    .start(start), .stop(stop), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .sel_out(sel_out), .wrap(wrap), .sel_err(sel_err)
  );

  chan_select_scanner #(.CHANNELS(3), .WIDTH(1), .DWELL(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .mode(mode3), .sel_in(sel_in3),
    .start(start3), .stop(stop3), .dout(dout3), .out_valid(valid3),
    .out_ready(ready3), .sel_out(sel_out3), .wrap(wrap3), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs are driven and outputs sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for out_valid on the 4-channel instance, bounded
  task automatic wait_valid(input int bound, output int cycles, output bit ok);
    cycles = 0;
    while (cycles < bound && !out_valid) begin
      tick();
      cycles++;
    end
    ok = out_valid;
  endtask

  // Run n clocks and report how many of them showed out_valid
  task automatic count_valid(input int n, output int nvalid);
    nvalid = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_valid) nvalid++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (dout !== 1'b0)      begin n_bad++; $display("FAIL reset_dout got %b want 0", dout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (sel_out !== 2'd0)   begin n_bad++; $display("FAIL reset_sel got %0d want 0", sel_out); end
    n_cmp++; if (wrap !== 1'b0 || sel_err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got wrap=%b err=%b want 0/0", wrap, sel_err); end
    n_cmp++; if (valid3 !== 1'b0 || sel_out3 !== 2'd0) begin n_bad++; $display("FAIL reset_dut3 got valid=%b sel=%0d want 0/0", valid3, sel_out3); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual();
    int  cyc;
    int  nv;
    bit  ok;
    din = 4'b0100; mode = 1'b0; sel_in = 2'd2; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, cyc, ok);
    // accept edge + DWELL edges = 5 rising edges from presenting start
    n_cmp++; if (!ok || cyc + 1 !== 5) begin n_bad++; $display("FAIL manual_latency got ok=%0d edges=%0d want 5", ok, cyc + 1); end
    n_cmp++; if (dout !== 1'b1)  begin n_bad++; $display("FAIL manual_dout got %b want 1", dout); end
    n_cmp++; if (sel_out !== 2'd2) begin n_bad++; $display("FAIL manual_sel got %0d want 2", sel_out); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL manual_handshake got valid=%b want 0", out_valid); end
    count_valid(10, nv);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL manual_idle got %0d valid cycles want 0", nv); end
  endtask

  task automatic test_async_reset();
    int nv;
    din = 4'b1000; mode = 1'b0; sel_in = 2'd3; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (sel_out !== 2'd3) begin n_bad++; $display("FAIL areset_pre_sel got %0d want 3", sel_out); end
    #2;
    rst_n = 1'b0;
    #1;
    // still in the low clock phase: no edge has happened since reset asserted
    n_cmp++; if (dout !== 1'b0)      begin n_bad++; $display("FAIL areset_dout got %b want 0", dout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b want 0", out_valid); end
    n_cmp++; if (sel_out !== 2'd0)   begin n_bad++; $display("FAIL areset_sel got %0d want 0", sel_out); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(10, nv);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL areset_discard got %0d valid cycles want 0", nv); end
  endtask

  task automatic test_scan();
    logic [4:0] exp_d;
    int         c;
    int         nv;
    int         nw;
    int         nidle;
    exp_d = 5'b01010;  // bit k = expected dout of k-th sample (ch0,1,2,3,0 of 1010)
    din = 4'b1010; mode = 1'b1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1; nv = 0; nw = 0;
    while (nv < 5 && c < 60) begin
      if (wrap) nw++;
      if (out_valid) begin
        n_cmp++; if (c !== 5 * (nv + 1)) begin n_bad++; $display("FAIL scan_time[%0d] got %0d want %0d", nv, c, 5 * (nv + 1)); end
        n_cmp++; if (dout !== exp_d[nv]) begin n_bad++; $display("FAIL scan_dout[%0d] got %b want %b", nv, dout, exp_d[nv]); end
        n_cmp++; if (sel_out !== 2'(nv % 4)) begin n_bad++; $display("FAIL scan_sel[%0d] got %0d want %0d", nv, sel_out, nv % 4); end
        nv++;
      end
      if (nv < 5) begin
        tick();
        c++;
      end
    end
    n_cmp++; if (nv !== 5) begin n_bad++; $display("FAIL scan_timeout got %0d samples want 5", nv); end
    n_cmp++; if (nw !== 1) begin n_bad++; $display("FAIL scan_wrap got %0d pulses want 1", nw); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || sel_out !== 2'd0) begin n_bad++; $display("FAIL scan_stop got valid=%b sel=%0d want 0/0", out_valid, sel_out); end
    count_valid(10, nidle);
    n_cmp++; if (nidle !== 0) begin n_bad++; $display("FAIL scan_stop_idle got %0d valid cycles want 0", nidle); end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    din = 4'b1010; mode = 1'b1; out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, cyc, ok);
    n_cmp++; if (!ok || dout !== 1'b0 || sel_out !== 2'd0) begin n_bad++; $display("FAIL bp_first got ok=%0d dout=%b sel=%0d want 1/0/0", ok, dout, sel_out); end
    for (int i = 0; i < 10; i++) begin
      din = ~din;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || dout !== 1'b0) begin n_bad++; $display("FAIL bp_hold[%0d] got valid=%b dout=%b want 1/0", i, out_valid, dout); end
    end
    din = 4'b1010;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got valid=%b want 0", out_valid); end
    wait_valid(20, cyc, ok);
    n_cmp++; if (!ok || cyc !== 4) begin n_bad++; $display("FAIL bp_next_latency got ok=%0d cycles=%0d want 4", ok, cyc); end
    n_cmp++; if (dout !== 1'b1 || sel_out !== 2'd1) begin n_bad++; $display("FAIL bp_next got dout=%b sel=%0d want 1/1", dout, sel_out); end
    tick(); tick(); tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_single got valid=%b want 1", out_valid); end
    stop = 1'b1; out_ready = 1'b1;
    tick();
    stop = 1'b0; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || sel_out !== 2'd1) begin n_bad++; $display("FAIL bp_stop got valid=%b sel=%0d want 0/1", out_valid, sel_out); end
  endtask

  task automatic test_stop();
    int cyc;
    int nv;
    bit ok;
    // stop while dwelling: no sample, dout keeps its previous value (1)
    din = 4'b0000; mode = 1'b1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    count_valid(10, nv);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL stop_dwell got %0d valid cycles want 0", nv); end
    n_cmp++; if (dout !== 1'b1 || sel_out !== 2'd1) begin n_bad++; $display("FAIL stop_dwell_hold got dout=%b sel=%0d want 1/1", dout, sel_out); end
    // stop while presenting: sample still delivered, channel not advanced
    din = 4'b0100; out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, cyc, ok);
    n_cmp++; if (!ok || dout !== 1'b0) begin n_bad++; $display("FAIL stop_present_sample got ok=%0d dout=%b want 1/0", ok, dout); end
    stop = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stop_present_pending got valid=%b want 1", out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; stop = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || sel_out !== 2'd1) begin n_bad++; $display("FAIL stop_present_done got valid=%b sel=%0d want 0/1", out_valid, sel_out); end
    out_ready = 1'b1;
    count_valid(10, nv);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL stop_present_idle got %0d valid cycles want 0", nv); end
  endtask

  task automatic test_start_stop();
    int nv;
    mode = 1'b0; sel_in = 2'd3; out_ready = 1'b1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (sel_out !== 2'd1 || sel_err !== 1'b0) begin n_bad++; $display("FAIL startstop_sel got sel=%0d err=%b want 1/0", sel_out, sel_err); end
    count_valid(10, nv);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL startstop_idle got %0d valid cycles want 0", nv); end
  endtask

  task automatic test_sel_err();
    int cyc;
    din3 = 3'b100; mode3 = 1'b0; sel_in3 = 2'd3; ready3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n_cmp++; if (sel_err3 !== 1'b1) begin n_bad++; $display("FAIL selerr_pulse got %b want 1", sel_err3); end
    n_cmp++; if (sel_out3 !== 2'd2) begin n_bad++; $display("FAIL selerr_clamp got %0d want 2", sel_out3); end
    tick();
    n_cmp++; if (sel_err3 !== 1'b0) begin n_bad++; $display("FAIL selerr_width got %b want 0", sel_err3); end
    cyc = 0;
    while (cyc < 20 && !valid3) begin
      tick();
      cyc++;
    end
    n_cmp++; if (valid3 !== 1'b1 || dout3 !== 1'b1) begin n_bad++; $display("FAIL selerr_sample got valid=%b dout=%b want 1/1", valid3, dout3); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    din = '0; mode = 1'b0; sel_in = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    din3 = '0; mode3 = 1'b0; sel_in3 = '0; start3 = 1'b0; stop3 = 1'b0; ready3 = 1'b0;
    @(negedge clk);
    test_reset();
    test_manual();
    test_async_reset();
    test_scan();
    test_backpressure();
    test_stop();
    test_start_stop();
    test_sel_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_chan_select_scanner
`default_nettype wire
